fetch_branch_predict: RTL and testbench

- Fetch-side predecode stage sitting between the I-cache response and the fetch queue.
- Accepts one fetch block of INSTR_PER_FETCH 32-bit instructions and predecodes JAL and conditional branches.
- Queries branch_history_table with each slot's PC and picks the first predicted-taken control instruction.
- Emits a one-cycle redirect to PC generation and pushes the masked block, with per-slot prediction bits, into a 2-entry output buffer toward decode.

---
 rtl/fetch_branch_predict_pkg.sv | 20 ++
 rtl/fetch_branch_predict_if.sv | 22 ++
 rtl/fetch_branch_predict_predecode.sv | 24 ++
 rtl/fetch_branch_predict.sv | 143 ++++++++++++++
 tb/tb_fetch_branch_predict.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_branch_predict_pkg.sv
// Shared types for the fetch predecode/predict slice: address type, fetch geometry,
// RISC-V opcode constants and the buffered fetch-block entry.
package riscv_pkg;
  localparam int ADDR_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

package tortoise_pkg;
  localparam int INSTR_PER_FETCH = 2;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef struct packed {
    riscv_pkg::addr_t                   pc;
    logic [INSTR_PER_FETCH-1:0][31:0]   instr;
    logic [INSTR_PER_FETCH-1:0]         mask;
    logic [INSTR_PER_FETCH-1:0]         taken;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_branch_predict_if.sv
// Output stream from the predict stage toward decode / fetch queue.
// master = fetch_branch_predict (producer), slave = consumer.
interface fetch_branch_predict_if #(
  parameter int NR_SLOTS = tortoise_pkg::INSTR_PER_FETCH
);
  logic                        out_valid_o;
  logic                        out_ready_i;
  riscv_pkg::addr_t            out_pc_o;
  logic [NR_SLOTS-1:0][31:0]   out_instr_o;
  logic [NR_SLOTS-1:0]         out_mask_o;
  logic [NR_SLOTS-1:0]         out_taken_o;

  modport master (
    output out_valid_o, out_pc_o, out_instr_o, out_mask_o, out_taken_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, out_pc_o, out_instr_o, out_mask_o, out_taken_o,
    output out_ready_i
  );
endinterface

// File: rtl/fetch_branch_predict_predecode.sv
// Per-slot predecode: flags JAL / conditional branch and returns the matching
// sign-extended immediate (J-type for JAL, B-type otherwise).
module fetch_predecode
  import tortoise_pkg::*;
(
  input  logic [31:0]      instr_i,
  output logic             is_jal_o,
  output logic             is_branch_o,
  output riscv_pkg::addr_t imm_o
);
  localparam int AW = riscv_pkg::ADDR_W;

  logic [20:0] j_imm;
  logic [12:0] b_imm;

  assign j_imm = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign b_imm = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};

  assign is_jal_o    = (instr_i[6:0] == OPCODE_JAL);
  assign is_branch_o = (instr_i[6:0] == OPCODE_BRANCH);

  assign imm_o = is_jal_o ? {{(AW-21){j_imm[20]}}, j_imm}
                          : {{(AW-13){b_imm[12]}}, b_imm};
endmodule

// File: rtl/fetch_branch_predict.sv
// Fetch predecode + branch prediction stage with a 2-entry skid buffer toward decode.
// Optional macro FETCH_PREDICT_BTFN_EN: invalid-BHT branches predict backward-taken.
module fetch_branch_predict
  import tortoise_pkg::*;
#(
  parameter int NR_SLOTS  = tortoise_pkg::INSTR_PER_FETCH,
  parameter int BUF_DEPTH = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              fetch_valid_i,
  output logic                              fetch_ready_o,
  input  riscv_pkg::addr_t                  fetch_pc_i,
  input  logic [NR_SLOTS-1:0][31:0]         fetch_data_i,
  output riscv_pkg::addr_t [NR_SLOTS-1:0]   bht_pc_o,
  input  logic [NR_SLOTS-1:0]               bht_valid_i,
  input  logic [NR_SLOTS-1:0]               bht_taken_i,
  output logic                              redirect_valid_o,
  output riscv_pkg::addr_t                  redirect_pc_o,
  fetch_branch_predict_if.master            out_bus
);
  typedef riscv_pkg::addr_t addr_t;

  localparam int    CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam addr_t BLK_MASK = addr_t'(NR_SLOTS * 4 - 1);

  addr_t                base_pc;
  addr_t                start_off;
  addr_t [NR_SLOTS-1:0] slot_pc;
  addr_t [NR_SLOTS-1:0] slot_imm;
  logic  [NR_SLOTS-1:0] slot_jal;
  logic  [NR_SLOTS-1:0] slot_br;
  logic  [NR_SLOTS-1:0] slot_taken;

  assign base_pc   = fetch_pc_i & ~BLK_MASK;
  assign start_off = (fetch_pc_i & BLK_MASK) >> 2;

  for (genvar i = 0; i < NR_SLOTS; i++) begin : g_slot
    assign slot_pc[i]  = base_pc + addr_t'(4 * i);
    assign bht_pc_o[i] = slot_pc[i];

    fetch_predecode u_predecode (
      .instr_i     (fetch_data_i[i]),
      .is_jal_o    (slot_jal[i]),
      .is_branch_o (slot_br[i]),
      .imm_o       (slot_imm[i])
    );

`ifdef FETCH_PREDICT_BTFN_EN
    assign slot_taken[i] = slot_jal[i] |
                           (slot_br[i] & (bht_valid_i[i] ? bht_taken_i[i]
                                                         : slot_imm[i][riscv_pkg::ADDR_W-1]));
`else
    assign slot_taken[i] = slot_jal[i] | (slot_br[i] & bht_valid_i[i] & bht_taken_i[i]);
`endif
  end

  // First taken slot at or after the start slot ends the block.
  logic                sel_found;
  logic [NR_SLOTS-1:0] sel_mask;
  logic [NR_SLOTS-1:0] sel_taken;
  addr_t               sel_target;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first,
  // so the loop-carried 'sel_found' chains in order and no latch is inferred.
  always_comb begin
    sel_found  = 1'b0;
    sel_mask   = '0;
    sel_taken  = '0;
    sel_target = '0;
    for (int i = 0; i < NR_SLOTS; i++) begin
      if (addr_t'(i) >= start_off && !sel_found) begin
        sel_mask[i] = 1'b1;
        if (slot_taken[i]) begin
          sel_found    = 1'b1;
          sel_taken[i] = 1'b1;
          sel_target   = slot_pc[i] + slot_imm[i];
        end
      end
    end
  end

  fetch_entry_t           buf_q [BUF_DEPTH];
  fetch_entry_t           new_entry;
  logic [CNT_W-1:0]       count_q;
  logic                   push;
  logic                   pop;
  logic                   redir_q;
  addr_t                  redir_pc_q;

  assign new_entry = '{pc: base_pc, instr: fetch_data_i, mask: sel_mask, taken: sel_taken};

  assign fetch_ready_o = (count_q < CNT_W'(BUF_DEPTH));
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop           = out_bus.out_valid_o && out_bus.out_ready_i;

  // NOTE: the buffer is only two entries, so it is reset like any register; empty slots are
  // also kept at zero, which makes the head outputs read 0 whenever the buffer is empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      // NOTE: state updates use non-blocking '<=' so every register sees pre-edge values.
      redir_q <= push && sel_found;
      if (push && sel_found) redir_pc_q <= sel_target;

      if (flush_i) begin
        count_q <= '0;
        for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            if (count_q == '0) buf_q[0] <= new_entry;
            else               buf_q[1] <= new_entry;
            count_q <= count_q + 1'b1;
          end
          2'b01: begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= '0;
            count_q  <= count_q - 1'b1;
          end
          // Push only coexists with pop at count 1: the new block replaces the head.
          2'b11:   buf_q[0] <= new_entry;
          default: ;
        endcase
      end
    end
  end

  // A flush in the redirect cycle suppresses the pulse the same cycle.
  assign redirect_valid_o = redir_q && !flush_i;
  assign redirect_pc_o    = redir_pc_q;

  assign out_bus.out_valid_o = (count_q != '0);
  assign out_bus.out_pc_o    = buf_q[0].pc;
  assign out_bus.out_instr_o = buf_q[0].instr;
  assign out_bus.out_mask_o  = buf_q[0].mask;
  assign out_bus.out_taken_o = buf_q[0].taken;
endmodule

// File: tb/tb_fetch_branch_predict.sv
// Directed self-checking bench for fetch_branch_predict (honours FETCH_PREDICT_BTFN_EN).
module tb_fetch_branch_predict;
  import riscv_pkg::*;

  localparam int NR = 2;
  localparam logic [31:0] JAL_P40 = 32'h0400_006F;  // jal x0, +0x40
  localparam logic [31:0] JAL_M10 = 32'hFF1F_F06F;  // jal x0, -0x10
  localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;  // beq x0, x0, -8
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  flush_i = 1'b0;
  logic                  fetch_valid_i = 1'b0;
  logic                  fetch_ready_o;
  addr_t                 fetch_pc_i = '0;
  logic [NR-1:0][31:0]   fetch_data_i = '0;
  addr_t [NR-1:0]        bht_pc_o;
  logic [NR-1:0]         bht_valid_i = '0;
  logic [NR-1:0]         bht_taken_i = '0;
  logic                  redirect_valid_o;
  addr_t                 redirect_pc_o;

  int checks = 0;
  int failures = 0;

  fetch_branch_predict_if #(.NR_SLOTS(NR)) bus ();

  fetch_branch_predict #(.NR_SLOTS(NR), .BUF_DEPTH(2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_ready_o    (fetch_ready_o),
    .fetch_pc_i       (fetch_pc_i),
    .fetch_data_i     (fetch_data_i),
    .bht_pc_o         (bht_pc_o),
    .bht_valid_i      (bht_valid_i),
    .bht_taken_i      (bht_taken_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .out_bus          (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input addr_t pc, input logic [31:0] s0, input logic [31:0] s1,
                         input logic [1:0] bv, input logic [1:0] bt);
    fetch_pc_i      = pc;
    fetch_data_i[0] = s0;
    fetch_data_i[1] = s1;
    bht_valid_i     = bv;
    bht_taken_i     = bt;
    fetch_valid_i   = 1'b1;
  endtask

  initial begin
    bus.out_ready_i = 1'b1;
    #12;
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_out_mask", 64'(bus.out_mask_o), 64'd0);
    check("rst_out_taken", 64'(bus.out_taken_o), 64'd0);
    check("rst_redirect", 64'(redirect_valid_o), 64'd0);
    check("rst_out_pc", 64'(bus.out_pc_o), 64'd0);
    rst_ni = 1'b1;
    tick();
    check("idle_ready", 64'(fetch_ready_o), 64'd1);

    // JAL +0x40 in slot 0 at 0x1000
    present(32'h1000, JAL_P40, NOP, 2'b00, 2'b00);
    #1;
    check("t1_bht_pc0", 64'(bht_pc_o[0]), 64'h1000);
    check("t1_bht_pc1", 64'(bht_pc_o[1]), 64'h1004);
    tick();
    fetch_valid_i = 1'b0;
    check("t1_redir_v", 64'(redirect_valid_o), 64'd1);
    check("t1_redir_pc", 64'(redirect_pc_o), 64'h1040);
    check("t1_out_valid", 64'(bus.out_valid_o), 64'd1);
    check("t1_out_pc", 64'(bus.out_pc_o), 64'h1000);
    check("t1_mask", 64'(bus.out_mask_o), 64'h1);
    check("t1_taken", 64'(bus.out_taken_o), 64'h1);
    check("t1_instr0", 64'(bus.out_instr_o[0]), 64'(JAL_P40));
    tick();
    check("t1_redir_pulse", 64'(redirect_valid_o), 64'd0);
    check("t1_popped", 64'(bus.out_valid_o), 64'd0);

    // start slot 1: slot-0 JAL ignored, BEQ -8 predicted taken by BHT
    present(32'h1004, JAL_P40, BEQ_M8, 2'b11, 2'b11);
    #1;
    check("t2_bht_pc0", 64'(bht_pc_o[0]), 64'h1000);
    tick();
    fetch_valid_i = 1'b0;
    check("t2_redir_v", 64'(redirect_valid_o), 64'd1);
    check("t2_redir_pc", 64'(redirect_pc_o), 64'h0FFC);
    check("t2_out_pc", 64'(bus.out_pc_o), 64'h1000);
    check("t2_mask", 64'(bus.out_mask_o), 64'h2);
    check("t2_taken", 64'(bus.out_taken_o), 64'h2);
    tick();

    // BEQ -8 with invalid BHT entry
    present(32'h2000, BEQ_M8, NOP, 2'b00, 2'b00);
    tick();
    fetch_valid_i = 1'b0;
`ifdef FETCH_PREDICT_BTFN_EN
    check("t3_redir_v", 64'(redirect_valid_o), 64'd1);
    check("t3_redir_pc", 64'(redirect_pc_o), 64'h1FF8);
    check("t3_mask", 64'(bus.out_mask_o), 64'h1);
    check("t3_taken", 64'(bus.out_taken_o), 64'h1);
`else
    check("t3_redir_v", 64'(redirect_valid_o), 64'd0);
    check("t3_mask", 64'(bus.out_mask_o), 64'h3);
    check("t3_taken", 64'(bus.out_taken_o), 64'h0);
`endif
    tick();

    // BEQ with valid BHT entry predicting not-taken
    present(32'h2000, BEQ_M8, NOP, 2'b01, 2'b00);
    tick();
    fetch_valid_i = 1'b0;
    check("t3b_redir_v", 64'(redirect_valid_o), 64'd0);
    check("t3b_mask", 64'(bus.out_mask_o), 64'h3);
    check("t3b_taken", 64'(bus.out_taken_o), 64'h0);
    tick();

    // backpressure: three blocks with out_ready low
    bus.out_ready_i = 1'b0;
    present(32'h3000, NOP, NOP, 2'b00, 2'b00);
    tick();
    check("t4_ready_after1", 64'(fetch_ready_o), 64'd1);
    present(32'h3008, NOP, NOP, 2'b00, 2'b00);
    tick();
    check("t4_ready_after2", 64'(fetch_ready_o), 64'd0);
    present(32'h3010, NOP, NOP, 2'b00, 2'b00);
    tick();
    check("t4_still_full", 64'(fetch_ready_o), 64'd0);
    check("t4_head_a", 64'(bus.out_pc_o), 64'h3000);
    bus.out_ready_i = 1'b1;
    tick();
    check("t4_head_b", 64'(bus.out_pc_o), 64'h3008);
    check("t4_ready_again", 64'(fetch_ready_o), 64'd1);
    tick();
    fetch_valid_i = 1'b0;
    check("t4_head_c", 64'(bus.out_pc_o), 64'h3010);
    check("t4_valid_c", 64'(bus.out_valid_o), 64'd1);
    tick();
    check("t4_drained", 64'(bus.out_valid_o), 64'd0);

    // flush in the redirect cycle
    present(32'h4000, JAL_P40, NOP, 2'b00, 2'b00);
    tick();
    fetch_valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    check("t5_redir_killed", 64'(redirect_valid_o), 64'd0);
    tick();
    check("t5_redir_after", 64'(redirect_valid_o), 64'd0);
    check("t5_empty", 64'(bus.out_valid_o), 64'd0);
    // block presented together with flush is dropped
    present(32'h4000, JAL_P40, NOP, 2'b00, 2'b00);
    tick();
    fetch_valid_i = 1'b0;
    flush_i = 1'b0;
    check("t5_drop_valid", 64'(bus.out_valid_o), 64'd0);
    check("t5_drop_redir", 64'(redirect_valid_o), 64'd0);
    tick();

    // target wrap
    present(32'h0000_0000, JAL_M10, NOP, 2'b00, 2'b00);
    tick();
    fetch_valid_i = 1'b0;
    check("t6_wrap_v", 64'(redirect_valid_o), 64'd1);
    check("t6_wrap_pc", 64'(redirect_pc_o), 64'hFFFF_FFF0);
    tick();

    // async reset mid-stream
    present(32'h5000, JAL_P40, NOP, 2'b00, 2'b00);
    tick();
    fetch_valid_i = 1'b0;
    check("t6_pre_rst_v", 64'(bus.out_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_redir", 64'(redirect_valid_o), 64'd0);
    check("t6_rst_redir_pc", 64'(redirect_pc_o), 64'd0);
    check("t6_rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("t6_rst_pc", 64'(bus.out_pc_o), 64'd0);
    check("t6_rst_mask", 64'(bus.out_mask_o), 64'd0);
    check("t6_rst_taken", 64'(bus.out_taken_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("t6_post_rst_redir", 64'(redirect_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
